jr_target_resolver: RTL
=======================

# jr_target_resolver

Parametrised register-indirect jump target resolver for the 5-stage pipeline, sitting in ID next to the register file. It selects the freshest value of the JR source register from EX, MEM, WB or the register file with fixed priority. It stalls ID on load-use and multi-cycle-load hazards, registers the resolved target with a one-cycle valid pulse, and keeps a saturating stall-cycle counter and a sticky timeout flag.

## Interface
- AW, 4, register address width
- DW, 16, data / target width
- ZERO_REG_EN, 1, register 0 is hardwired zero: never matched for forwarding, always resolves to 0
- MAX_WAIT, 7, stall cycles allowed before timeout_err sets (1..255)
- PERF_W, 16, width of stall_cycles counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- jr_valid  in  1  JR instruction in ID; held with jr_src stable while stall=1
- jr_src  in  AW  JR source register
- flush  in  1  kill the JR in ID (redirect from a later stage)
- ex_dst, mem_dst, wb_dst  in  AW  destination register per stage
- ex_we, mem_we, wb_we  in  1  register write enable per stage
- ex_mem_re, mem_mem_re  in  1  stage instruction is a load
- mem_ld_valid  in  1  load data on mem_ld_data is valid this cycle
- ex_data, mem_alu_data, mem_ld_data, wb_data, rf_data  in  DW  candidate values
- stall  out  1  freeze PC/IF/ID, bubble into EX (combinational)
- jr_target  out  DW  registered resolved target
- jr_target_valid  out  1  one-cycle pulse, jr_target valid
- fwd_src  out  3  registered source of last target: 0 RF, 1 EX, 2 MEM ALU, 3 MEM load, 4 WB, 5 zero reg
- stall_cycles  out  PERF_W  saturating count of stall cycles
- timeout_err  out  1  sticky, set when a wait exceeds MAX_WAIT

## Operation
- Match per stage is jr_src==X_dst && X_we, and with ZERO_REG_EN also jr_src!=0.
- Priority: EX > MEM > WB > RF. The youngest matching stage always wins; older matches are ignored.
- The JR is unresolvable if either condition holds:
  - EX match with ex_mem_re=1 (load-use).
  - EX does not match, MEM matches, mem_mem_re=1 and mem_ld_valid=0.
- Otherwise it is resolvable. Value by winner: ex_data, mem_alu_data (mem_mem_re=0), mem_ld_data, wb_data, else rf_data. With ZERO_REG_EN and jr_src=0 the value is 0 and fwd_src=5.
- FSM states: IDLE and WAIT.
  - IDLE, jr_valid=1, flush=0, resolvable: capture the target; stay in IDLE.
  - IDLE, jr_valid=1, flush=0, unresolvable: go to WAIT; wait_cnt=1.
  - WAIT: re-evaluate every cycle against live pipeline inputs.
    - Resolvable: capture the target and go to IDLE.
    - Otherwise: stay in WAIT; wait_cnt increments, saturating at 255.
  - Any state with flush=1: go to IDLE, no capture, wait_cnt=0.
- stall = jr_valid & ~flush & ~resolvable, in either state.
- A capture registers jr_target and fwd_src and pulses jr_target_valid the next cycle.
- stall_cycles increments on every cycle with stall=1 and saturates at 2^PERF_W−1.
- timeout_err sets when wait_cnt would exceed MAX_WAIT. It clears only on reset. The stall continues regardless.
- Back-to-back JRs in consecutive ID cycles each resolve independently; each produces its own pulse.

## Timing
- Reset (async assert, sync-released use): state=IDLE, wait_cnt=0, jr_target=0, jr_target_valid=0, fwd_src=0, stall_cycles=0, timeout_err=0. stall is 0 while jr_valid=0.
- Resolvable JR: stall=0. Target appears on the next rising edge with jr_target_valid=1 for exactly one cycle.
- Load-use (EX load match): at least one stall cycle. Resolves from MEM load data in the cycle mem_ld_valid=1; target one edge later.
- flush together with an unresolvable JR: stall=0 that cycle, no pulse, FSM to IDLE.
- Reset mid-WAIT: all state clears immediately; no pulse after release.
- jr_valid=0 in WAIT without flush is a protocol violation. Required behaviour: stall=0, return to IDLE, no pulse.

## Test plan
- Priority: jr_src=3, EX/MEM/WB all write r3 (non-load) with ex_data=0x1111, mem_alu_data=0x2222, wb_data=0x3333 -> stall=0; next cycle jr_target=0x1111, fwd_src=1, one-cycle pulse.
- Load-use: jr_src=5, EX load to r5. Next cycle MEM load to r5 with mem_ld_valid=0 for 2 cycles, then 1 with mem_ld_data=0xBEEF -> stall high 3 cycles; target 0xBEEF, fwd_src=3; stall_cycles=3.
- Zero register: jr_src=0, EX writes r0 with ex_data=0xFFFF -> no stall; jr_target=0x0000, fwd_src=5.
- Flush mid-WAIT: enter WAIT via load-use, assert flush on the 2nd stall cycle -> stall drops that cycle, no pulse, state IDLE.
- Timeout: MAX_WAIT=2, mem_ld_valid held 0 for 5 cycles -> timeout_err sets on the 3rd wait cycle and stays set through the later resolution and further JRs.
- Async reset asserted in WAIT with stall_cycles=4 -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/jr_target_resolver.sv
// ---------------------------------------------------------------------------
// jr_target_resolver
//
// Resolves the target of a register-indirect jump (JR) in the ID stage.
// It picks the freshest copy of the JR source register from EX, MEM, WB or
// the register file, with the youngest stage taking priority. When the value
// is not yet available (load in EX, or a load in MEM whose data has not
// arrived) it stalls ID and re-evaluates every cycle. A resolved target is
// registered and flagged with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   jr_valid_i, jr_src_i    JR present in ID and its source register
//   flush_i                 kill the JR in ID
//   {ex,mem,wb}_dst_i/_we_i destination register / write enable per stage
//   ex_mem_re_i, mem_mem_re_i  stage holds a load
//   mem_ld_valid_i          load data on mem_ld_data_i is valid
//   *_data_i                candidate values (EX, MEM ALU, MEM load, WB, RF)
//   stall_o                 combinational freeze of PC/IF/ID
//   jr_target_o, jr_target_valid_o, fwd_src_o   registered result
//   stall_cycles_o          saturating count of stall cycles
//   timeout_err_o           sticky flag: a wait ran longer than MAX_WAIT
// ---------------------------------------------------------------------------
module jr_target_resolver #(
    parameter int AW          = 4,
    parameter int DW          = 16,
    parameter bit ZERO_REG_EN = 1'b1,
    parameter int MAX_WAIT    = 7,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jr_valid_i,
    input  logic [AW-1:0]     jr_src_i,
    input  logic              flush_i,
    input  logic [AW-1:0]     ex_dst_i,
    input  logic [AW-1:0]     mem_dst_i,
    input  logic [AW-1:0]     wb_dst_i,
    input  logic              ex_we_i,
    input  logic              mem_we_i,
    input  logic              wb_we_i,
    input  logic              ex_mem_re_i,
    input  logic              mem_mem_re_i,
    input  logic              mem_ld_valid_i,
    input  logic [DW-1:0]     ex_data_i,
    input  logic [DW-1:0]     mem_alu_data_i,
    input  logic [DW-1:0]     mem_ld_data_i,
    input  logic [DW-1:0]     wb_data_i,
    input  logic [DW-1:0]     rf_data_i,
    output logic              stall_o,
    output logic [DW-1:0]     jr_target_o,
    output logic              jr_target_valid_o,
    output logic [2:0]        fwd_src_o,
    output logic [PERF_W-1:0] stall_cycles_o,
    output logic              timeout_err_o
);

    typedef enum logic [2:0] {
        SRC_RF      = 3'd0,
        SRC_EX      = 3'd1,
        SRC_MEM_ALU = 3'd2,
        SRC_MEM_LD  = 3'd3,
        SRC_WB      = 3'd4,
        SRC_ZERO    = 3'd5
    } fwd_src_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [DW-1:0]     jr_target_q;
    logic [2:0]        fwd_src_q;
    logic              valid_q;
    logic [PERF_W-1:0] stall_cycles_q;
    logic              timeout_err_q, timeout_err_d;

    logic              is_zero, m_ex, m_mem, m_wb;
    logic              unresolvable, capture;
    logic [DW-1:0]     sel_value;
    fwd_src_e          sel_src;

    // Operand selection: youngest matching stage wins.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, otherwise an unassigned path infers a latch.
        sel_value = rf_data_i;
        sel_src   = SRC_RF;

        is_zero = ZERO_REG_EN && (jr_src_i == '0);
        m_ex    = ex_we_i  && (ex_dst_i  == jr_src_i) && !is_zero;
        m_mem   = mem_we_i && (mem_dst_i == jr_src_i) && !is_zero;
        m_wb    = wb_we_i  && (wb_dst_i  == jr_src_i) && !is_zero;

        // A load in EX can never be forwarded; a load in MEM only once its
        // data has arrived. An older MEM load is irrelevant when EX matches.
        unresolvable = (m_ex && ex_mem_re_i) ||
                       (!m_ex && m_mem && mem_mem_re_i && !mem_ld_valid_i);

        if (is_zero) begin
            sel_value = '0;
            sel_src   = SRC_ZERO;
        end else if (m_ex) begin
            sel_value = ex_data_i;
            sel_src   = SRC_EX;
        end else if (m_mem) begin
            sel_value = mem_mem_re_i ? mem_ld_data_i : mem_alu_data_i;
            sel_src   = mem_mem_re_i ? SRC_MEM_LD : SRC_MEM_ALU;
        end else if (m_wb) begin
            sel_value = wb_data_i;
            sel_src   = SRC_WB;
        end
    end

    assign stall_o = jr_valid_i && !flush_i && unresolvable;

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        capture    = 1'b0;

        if (flush_i) begin
            state_d    = IDLE;
            wait_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (jr_valid_i) begin
                        if (unresolvable) begin
                            state_d    = WAIT;
                            wait_cnt_d = 8'd1;
                        end else begin
                            capture = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!jr_valid_i) begin
                        // JR vanished without a flush: drop it quietly.
                        state_d    = IDLE;
                        wait_cnt_d = '0;
                    end else if (unresolvable) begin
                        if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
                    end else begin
                        capture    = 1'b1;
                        state_d    = IDLE;
                        wait_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end
            endcase
        end

        timeout_err_d = timeout_err_q || (stall_o && (wait_cnt_d > MAX_WAIT_C));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the target/source registers are reset too, so the
            // outputs are defined straight out of reset, not just after the
            // first pulse.
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            jr_target_q    <= '0;
            fwd_src_q      <= SRC_RF;
            valid_q        <= 1'b0;
            stall_cycles_q <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // the pre-edge values, independent of statement order.
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            valid_q       <= capture;
            timeout_err_q <= timeout_err_d;
            if (capture) begin
                jr_target_q <= sel_value;
                fwd_src_q   <= sel_src;
            end
            if (stall_o && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
        end
    end

    assign jr_target_o       = jr_target_q;
    assign jr_target_valid_o = valid_q;
    assign fwd_src_o         = fwd_src_q;
    assign stall_cycles_o    = stall_cycles_q;
    assign timeout_err_o     = timeout_err_q;

endmodule
